escalonador_somador: RTL and testbench

//  Shares one LARGURA-bit ripple adder between two requesters via round-robin arbitration.

---
 rtl/escalonador_pkg.sv | 29 ++
 rtl/somador_nibble.sv | 22 ++
 rtl/escalonador_somador.sv | 134 +++++++++++++
 tb/tb_escalonador_somador.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/escalonador_pkg.sv
// rtl/escalonador_pkg.sv - shared types, constants and BCD helper for escalonador_somador
package escalonador_pkg;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CALCULA = 2'd1,
        ENTREGA = 2'd2
    } estado_t;

    localparam logic REQ0     = 1'b0;
    localparam logic REQ1     = 1'b1;
    localparam int   BCD_BASE = 10;

    // Six unrolled compare-subtract steps cover any 6-bit sum (0..63) without a divider.
    function automatic logic [7:0] bcd_de_soma(input logic [5:0] v);
        logic [5:0] r_resto;
        logic [3:0] r_dez;
        r_resto = v;
        r_dez   = 4'd0;
        for (int i = 0; i < 6; i++) begin
            if (r_resto >= 6'(BCD_BASE)) begin
                r_resto = r_resto - 6'(BCD_BASE);
                r_dez   = r_dez + 4'd1;
            end
        end
        return {r_dez, r_resto[3:0]};
    endfunction

endpackage

// File: rtl/somador_nibble.sv
// rtl/somador_nibble.sv - combinational LARGURA-bit ripple-carry adder
module somador_nibble #(
    parameter int LARGURA = 4
) (
    input  logic [LARGURA-1:0] a,
    input  logic [LARGURA-1:0] b,
    output logic [LARGURA-1:0] soma,
    output logic               cout
);

    logic [LARGURA:0] w_carry;

    assign w_carry[0] = 1'b0;

    for (genvar i = 0; i < LARGURA; i++) begin : g_fa
        assign soma[i]        = a[i] ^ b[i] ^ w_carry[i];
        assign w_carry[i + 1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
    end

    assign cout = w_carry[LARGURA];

endmodule

// File: rtl/escalonador_somador.sv
// rtl/escalonador_somador.sv - round-robin shared adder for two requesters (optional BCD digits: BCD_SAIDA_EN)
module escalonador_somador
    import escalonador_pkg::*;
#(
    parameter int LARGURA = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req,
    input  logic [LARGURA-1:0] op_a0,
    input  logic [LARGURA-1:0] op_b0,
    input  logic [LARGURA-1:0] op_a1,
    input  logic [LARGURA-1:0] op_b1,
    output logic [1:0]         gnt,
    output logic [1:0]         done,
    output logic [LARGURA-1:0] soma,
    output logic               cout,
    output logic               ocupado,
    output logic [3:0]         dig_dez,
    output logic [3:0]         dig_uni
);

    estado_t            r_estado;
    logic               r_prio;
    logic               r_w;
    logic [LARGURA-1:0] r_a;
    logic [LARGURA-1:0] r_b;
    logic [LARGURA-1:0] r_soma;
    logic               r_cout;
    logic [1:0]         r_gnt;
    logic [1:0]         r_done;

    logic               w_vencedor;
    logic [LARGURA-1:0] w_op_a;
    logic [LARGURA-1:0] w_op_b;
    logic [LARGURA-1:0] w_soma;
    logic               w_cout;

    // A lone requester always wins; on contention the priority pointer decides.
    always_comb begin
        w_vencedor = REQ0;
        if (req == 2'b11) begin
            w_vencedor = r_prio;
        end else if (req == 2'b10) begin
            w_vencedor = REQ1;
        end
    end

    assign w_op_a = (w_vencedor == REQ1) ? op_a1 : op_a0;
    assign w_op_b = (w_vencedor == REQ1) ? op_b1 : op_b0;

    somador_nibble #(.LARGURA(LARGURA)) u_somador (
        .a    (r_a),
        .b    (r_b),
        .soma (w_soma),
        .cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_estado <= OCIOSO;
            r_prio   <= REQ0;
            r_w      <= REQ0;
            r_a      <= '0;
            r_b      <= '0;
            r_soma   <= '0;
            r_cout   <= 1'b0;
            r_gnt    <= 2'b00;
            r_done   <= 2'b00;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    r_done <= 2'b00;
                    r_gnt  <= 2'b00;
                    if (req != 2'b00) begin
                        r_w      <= w_vencedor;
                        r_a      <= w_op_a;
                        r_b      <= w_op_b;
                        r_gnt    <= (w_vencedor == REQ1) ? 2'b10 : 2'b01;
                        r_prio   <= ~w_vencedor;
                        r_estado <= CALCULA;
                    end
                end
                CALCULA: begin
                    r_gnt    <= 2'b00;
                    r_soma   <= w_soma;
                    r_cout   <= w_cout;
                    r_done   <= (r_w == REQ1) ? 2'b10 : 2'b01;
                    r_estado <= ENTREGA;
                end
                ENTREGA: begin
                    r_done   <= 2'b00;
                    r_estado <= OCIOSO;
                end
                default: begin
                    r_gnt    <= 2'b00;
                    r_done   <= 2'b00;
                    r_estado <= OCIOSO;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign done    = r_done;
    assign soma    = r_soma;
    assign cout    = r_cout;
    assign ocupado = (r_estado != OCIOSO);

`ifdef BCD_SAIDA_EN
    logic [3:0] r_dig_dez;
    logic [3:0] r_dig_uni;
    logic [7:0] w_bcd;

    assign w_bcd = bcd_de_soma(6'({w_cout, w_soma}));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dig_dez <= 4'd0;
            r_dig_uni <= 4'd0;
        end else if (r_estado == CALCULA) begin
            r_dig_dez <= w_bcd[7:4];
            r_dig_uni <= w_bcd[3:0];
        end
    end

    assign dig_dez = r_dig_dez;
    assign dig_uni = r_dig_uni;
`else
    assign dig_dez = 4'd0;
    assign dig_uni = 4'd0;
`endif

endmodule

// File: tb/tb_escalonador_somador.sv
// tb/tb_escalonador_somador.sv - directed and randomized check of escalonador_somador
module tb_escalonador_somador;

    localparam int L = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req;
    logic [L-1:0] op_a0, op_b0, op_a1, op_b1;
    logic [1:0]   gnt, done;
    logic [L-1:0] soma;
    logic         cout, ocupado;
    logic [3:0]   dig_dez, dig_uni;

    int n_vec = 0;
    int n_err = 0;
    int m_prio = 0;
    int m_sum = 0;

    escalonador_somador #(.LARGURA(L)) dut (
        .clk(clk), .rst(rst), .req(req),
        .op_a0(op_a0), .op_b0(op_b0), .op_a1(op_a1), .op_b1(op_b1),
        .gnt(gnt), .done(done), .soma(soma), .cout(cout), .ocupado(ocupado),
        .dig_dez(dig_dez), .dig_uni(dig_uni)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_dez();
`ifdef BCD_SAIDA_EN
        return m_sum / 10;
`else
        return 0;
`endif
    endfunction

    function automatic int exp_uni();
`ifdef BCD_SAIDA_EN
        return m_sum % 10;
`else
        return 0;
`endif
    endfunction

    task automatic chk_result(input string tag);
        chk({tag, ".soma"}, 32'(soma), m_sum % (1 << L));
        chk({tag, ".cout"}, 32'(cout), m_sum / (1 << L));
        chk({tag, ".dez"}, 32'(dig_dez), exp_dez());
        chk({tag, ".uni"}, 32'(dig_uni), exp_uni());
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".gnt"}, 32'(gnt), 0);
        chk({tag, ".done"}, 32'(done), 0);
        chk({tag, ".ocupado"}, 32'(ocupado), 0);
        chk_result(tag);
    endtask

    task automatic apply_reset(input logic [1:0] r);
        rst = 1'b1;
        req = r;
        m_prio = 0;
        m_sum = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk_idle("reset");
        end
        rst = 1'b0;
        req = 2'b00;
    endtask

    // One complete transaction: grant, result, return to idle. Operands are
    // scrambled after the grant to prove they were captured, not re-sampled.
    task automatic do_op(input string tag, input logic [1:0] r, input int a0, input int b0,
                         input int a1, input int b1, input bit hold);
        int w;
        int s;
        req = r;
        op_a0 = L'(a0); op_b0 = L'(b0); op_a1 = L'(a1); op_b1 = L'(b1);
        w = (r == 2'b11) ? m_prio : ((r == 2'b10) ? 1 : 0);
        s = (w == 1) ? (a1 + b1) : (a0 + b0);
        step();
        chk({tag, ".gnt"}, 32'(gnt), 1 << w);
        chk({tag, ".done_early"}, 32'(done), 0);
        chk({tag, ".ocupado"}, 32'(ocupado), 1);
        chk_result({tag, ".held"});
        m_prio = 1 - w;
        op_a0 = L'($urandom); op_b0 = L'($urandom); op_a1 = L'($urandom); op_b1 = L'($urandom);
        if (!hold) req = 2'b00;
        step();
        m_sum = s;
        chk({tag, ".done"}, 32'(done), 1 << w);
        chk({tag, ".gnt_off"}, 32'(gnt), 0);
        chk({tag, ".ocupado2"}, 32'(ocupado), 1);
        chk_result(tag);
        step();
        chk_idle({tag, ".end"});
    endtask

    initial begin
        rst = 1'b0;
        req = 2'b00;
        op_a0 = '0; op_b0 = '0; op_a1 = '0; op_b1 = '0;

        apply_reset(2'b11);

        do_op("single0", 2'b01, 9, 8, 0, 0, 1'b0);

        apply_reset(2'b00);
        do_op("both_a", 2'b11, 3, 4, 15, 15, 1'b1);
        do_op("both_b", 2'b11, 3, 4, 15, 15, 1'b0);

        for (int i = 0; i < 4; i++) begin
            do_op("alt", 2'b11, $urandom_range(0, (1 << L) - 1), $urandom_range(0, (1 << L) - 1),
                  $urandom_range(0, (1 << L) - 1), $urandom_range(0, (1 << L) - 1), 1'b1);
        end
        req = 2'b00;
        step();
        chk_idle("idle");

        req = 2'b01;
        op_a0 = L'(5); op_b0 = L'(5);
        step();
        chk("midrst.gnt", 32'(gnt), 1);
        rst = 1'b1;
        req = 2'b00;
        step();
        m_prio = 0;
        m_sum = 0;
        chk_idle("midrst");
        rst = 1'b0;
        step();
        chk_idle("midrst.after");
        do_op("postrst", 2'b11, 9, 9, 1, 2, 1'b0);

        for (int i = 0; i < 30; i++) begin
            int idle_cycles;
            do_op("rand", 2'($urandom_range(1, 3)), $urandom_range(0, (1 << L) - 1),
                  $urandom_range(0, (1 << L) - 1), $urandom_range(0, (1 << L) - 1),
                  $urandom_range(0, (1 << L) - 1), 1'($urandom_range(0, 1)));
            req = 2'b00;
            idle_cycles = $urandom_range(0, 2);
            for (int j = 0; j < idle_cycles; j++) begin
                step();
                chk_idle("rand.idle");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
